// File: rtl/gpio_cfg_if.sv
// Sequencer bus: start/abort control, register-file read port and pad chain outputs.
interface gpio_cfg_if #(
   parameter int unsigned NUM_IO   = 38,
   parameter int unsigned CFG_BITS = 13
);
   localparam int unsigned IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

   logic                start;
   logic                abort;
   logic [IDX_W-1:0]    cfg_idx;
   logic [CFG_BITS-1:0] cfg_word;
   logic                busy;
   logic                done;
   logic                serial_clock;
   logic                serial_data;
   logic                serial_load;

   // Sequencer side: reads the register file and drives the pad chain.
   modport master (
      input  start,
      input  abort,
      input  cfg_word,
      output cfg_idx,
      output busy,
      output done,
      output serial_clock,
      output serial_data,
      output serial_load
   );

   // Host / register file / pad chain side.
   modport slave (
      output start,
      output abort,
      output cfg_word,
      input  cfg_idx,
      input  busy,
      input  done,
      input  serial_clock,
      input  serial_data,
      input  serial_load
   );
endinterface

// File: rtl/gpio_cfg_sequencer.sv
// Serial configuration sequencer for the user-area GPIO pad chain.
// Shifts one word per pad (last pad first, MSB first) into the chain,
// then strobes serial_load so all pads apply their settings together.
module gpio_cfg_sequencer #(
   parameter int unsigned NUM_IO   = 38,
   parameter int unsigned CFG_BITS = 13,
   parameter int unsigned DIV      = 2
) (
   input logic        clk,
   input logic        resetn,
   gpio_cfg_if.master bus
);
   localparam int unsigned IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
   localparam int unsigned BIT_W = $clog2(CFG_BITS);
   localparam int unsigned PH_W  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IO - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_BITS - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      CLK_LO = 3'd2,
      CLK_HI = 3'd3,
      LOAD   = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CFG_BITS-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                sclk_q, sclk_d;
   logic                sload_q, sload_d;
   logic                phase_end;

   // Last cycle of the current DIV-long serial phase.
   assign phase_end = (phase_q == '0);

   // State, datapath and registered output flops.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         phase_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sclk_q   <= 1'b0;
         sload_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         phase_q  <= phase_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sclk_q   <= sclk_d;
         sload_q  <= sload_d;
      end
   end

   // Next-state, datapath update and output decode of the next state.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      phase_d  = phase_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      sclk_d   = 1'b0;
      sload_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               idx_d   = IDX_LAST;
               state_d = FETCH;
            end
         end
         FETCH: begin
            // cfg_word only has to be valid here; the word is held in shreg after.
            shreg_d  = bus.cfg_word;
            bitcnt_d = BIT_LAST;
            phase_d  = PH_LAST;
            state_d  = CLK_LO;
         end
         CLK_LO: begin
            if (phase_end) begin
               phase_d = PH_LAST;
               state_d = CLK_HI;
            end else begin
               phase_d = phase_q - PH_W'(1);
            end
         end
         CLK_HI: begin
            if (phase_end) begin
               phase_d = PH_LAST;
               if (bitcnt_q != '0) begin
                  // Shift only on leaving the high phase so data moves with the falling edge.
                  shreg_d  = {shreg_q[CFG_BITS-2:0], 1'b0};
                  bitcnt_d = bitcnt_q - BIT_W'(1);
                  state_d  = CLK_LO;
               end else if (idx_q != '0) begin
                  idx_d   = idx_q - IDX_W'(1);
                  state_d = FETCH;
               end else begin
                  state_d = LOAD;
               end
            end else begin
               phase_d = phase_q - PH_W'(1);
            end
         end
         LOAD: begin
            if (phase_end) begin
               state_d = DONE;
            end else begin
               phase_d = phase_q - PH_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over everything outside IDLE; the load strobe is never reached.
      if (bus.abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end

      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
      sclk_d  = (state_d == CLK_HI);
      sload_d = (state_d == LOAD);
   end

   // Bus outputs are taken straight from flops.
   assign bus.cfg_idx      = idx_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.serial_clock = sclk_q;
   assign bus.serial_data  = shreg_q[CFG_BITS-1];
   assign bus.serial_load  = sload_q;

   // Load strobe and shift clock are mutually exclusive.
   a_no_load_while_clk_high : assert property (
      @(posedge clk) disable iff (!resetn) !(sload_q && sclk_q));

   // Shift data holds steady across the whole high phase of the serial clock.
   a_data_stable_high : assert property (
      @(posedge clk) disable iff (!resetn)
      (sclk_q && $past(sclk_q)) |-> $stable(shreg_q[CFG_BITS-1]));

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Bench for gpio_cfg_sequencer: a small chain (2x4 bits, DIV=1) for exact
// timing and bit-order vectors, and the default chain (38x13, DIV=2) with a
// pad-chain model that latches applied config on serial_load.
module tb_gpio_cfg_sequencer;
   localparam int unsigned A_IO   = 2;
   localparam int unsigned A_CB   = 4;
   localparam int unsigned A_DIV  = 1;
   localparam int unsigned B_IO   = 38;
   localparam int unsigned B_CB   = 13;
   localparam int unsigned B_DIV  = 2;
   localparam int unsigned B_BITS = B_IO * B_CB;

   logic clk;
   logic resetn;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   gpio_cfg_if #(.NUM_IO(A_IO), .CFG_BITS(A_CB)) bus_a ();
   gpio_cfg_if #(.NUM_IO(B_IO), .CFG_BITS(B_CB)) bus_b ();

   gpio_cfg_sequencer #(.NUM_IO(A_IO), .CFG_BITS(A_CB), .DIV(A_DIV)) dut_a (
      .clk(clk), .resetn(resetn), .bus(bus_a));
   gpio_cfg_sequencer #(.NUM_IO(B_IO), .CFG_BITS(B_CB), .DIV(B_DIV)) dut_b (
      .clk(clk), .resetn(resetn), .bus(bus_b));

   // Register files with zero-latency read.
   logic [A_CB-1:0] rf_a [A_IO];
   logic [B_CB-1:0] rf_b [B_IO];
   assign bus_a.cfg_word = rf_a[bus_a.cfg_idx];
   assign bus_b.cfg_word = rf_b[bus_b.cfg_idx];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got unexpected event, want none", name);
   endtask

   // Scoreboards: expected serial bits (and pad index) in shift order.
   logic        exp_bit_a [$];
   int unsigned exp_idx_a [$];
   logic        exp_bit_b [$];

   // Monitor for the small chain.
   logic sc_prev_a = 1'b0;
   logic ld_prev_a = 1'b0;
   int   loads_a   = 0;
   int   load_hi_a = 0;
   int   dones_a   = 0;
   always @(negedge clk) begin
      if (bus_a.serial_clock && !sc_prev_a) begin
         if (exp_bit_a.size() == 0) begin
            fail("a_extra_edge");
         end else begin
            chk("a_bit", 64'(bus_a.serial_data), 64'(exp_bit_a.pop_front()));
            chk("a_idx", 64'(bus_a.cfg_idx), 64'(exp_idx_a.pop_front()));
         end
      end
      if (bus_a.serial_load) load_hi_a++;
      if (bus_a.serial_load && !ld_prev_a) loads_a++;
      if (bus_a.done) dones_a++;
      sc_prev_a = bus_a.serial_clock;
      ld_prev_a = bus_a.serial_load;
   end

   // Monitor and pad-chain model for the default chain.
   logic [B_BITS-1:0] chain_b = '0;
   logic [B_CB-1:0]   applied_b [B_IO];
   logic sc_prev_b = 1'b0;
   logic ld_prev_b = 1'b0;
   int   loads_b   = 0;
   int   load_hi_b = 0;
   int   dones_b   = 0;
   always @(negedge clk) begin
      if (bus_b.serial_clock && !sc_prev_b) begin
         if (exp_bit_b.size() == 0) begin
            fail("b_extra_edge");
         end else begin
            chk("b_bit", 64'(bus_b.serial_data), 64'(exp_bit_b.pop_front()));
         end
         chain_b = {chain_b[B_BITS-2:0], bus_b.serial_data};
      end
      if (bus_b.serial_load) load_hi_b++;
      if (bus_b.serial_load && !ld_prev_b) begin
         loads_b++;
         for (int p = 0; p < int'(B_IO); p++) applied_b[p] = chain_b[p*B_CB +: B_CB];
      end
      if (bus_b.done) dones_b++;
      sc_prev_b = bus_b.serial_clock;
      ld_prev_b = bus_b.serial_load;
   end

   task automatic push_a(input logic [A_CB-1:0] w1, input logic [A_CB-1:0] w0);
      for (int i = A_CB - 1; i >= 0; i--) begin
         exp_bit_a.push_back(w1[i]);
         exp_idx_a.push_back(1);
      end
      for (int i = A_CB - 1; i >= 0; i--) begin
         exp_bit_a.push_back(w0[i]);
         exp_idx_a.push_back(0);
      end
   endtask

   task automatic push_b();
      for (int p = B_IO - 1; p >= 0; p--)
         for (int b = B_CB - 1; b >= 0; b--) exp_bit_b.push_back(rf_b[p][b]);
   endtask

   // One-cycle start pulse; returns just after the edge that samples it.
   task automatic pulse(input bit on_b);
      @(posedge clk); #1;
      if (on_b) bus_b.start = 1'b1;
      else      bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
   endtask

   // Counts busy cycles after the start cycle until busy falls (bounded).
   task automatic measure_a(input int budget, input int mutate_at,
                            output int busy_n, output int done_at);
      busy_n  = 0;
      done_at = 0;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         if (n == mutate_at) rf_a[1] = ~rf_a[1];
         if (bus_a.busy) busy_n++;
         if (bus_a.done) done_at = n;
         if (!bus_a.busy) break;
      end
   endtask

   task automatic run_b_full(input string tag);
      int busy_n, done_at, first_edge, l0, h0, d0, mism;
      push_b();
      l0 = loads_b; h0 = load_hi_b; d0 = dones_b;
      pulse(1'b1);
      busy_n = 0; done_at = 0; first_edge = 0;
      for (int n = 1; n <= 2100; n++) begin
         @(negedge clk);
         if (bus_b.busy) busy_n++;
         if (bus_b.done) done_at = n;
         if (bus_b.serial_clock && first_edge == 0) first_edge = n;
         if (!bus_b.busy) break;
      end
      @(negedge clk);
      chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(2017));
      chk({tag, "_done_cycle"}, 64'(done_at), 64'(2017));
      chk({tag, "_first_edge"}, 64'(first_edge), 64'(4));
      chk({tag, "_loads"}, 64'(loads_b - l0), 64'(1));
      chk({tag, "_load_len"}, 64'(load_hi_b - h0), 64'(B_DIV));
      chk({tag, "_dones"}, 64'(dones_b - d0), 64'(1));
      chk({tag, "_bits_left"}, 64'(exp_bit_b.size()), 64'(0));
      mism = 0;
      for (int p = 0; p < int'(B_IO); p++) if (applied_b[p] !== rf_b[p]) mism++;
      chk({tag, "_applied_mismatch_pads"}, 64'(mism), 64'(0));
   endtask

   typedef struct {
      logic [A_CB-1:0] w1;
      logic [A_CB-1:0] w0;
      logic [7:0]      stream;
      bit              mutate;
   } vec_t;

   vec_t            vecs [4];
   int              busy_n, done_at, l0, h0, d0, mism;
   logic [B_CB-1:0] saved_b [B_IO];

   initial begin
      vecs[0] = '{w1: 4'b1010, w0: 4'b0011, stream: 8'b1010_0011, mutate: 1'b0};
      vecs[1] = '{w1: 4'b1111, w0: 4'b0000, stream: 8'b1111_0000, mutate: 1'b1};
      vecs[2] = '{w1: 4'b1000, w0: 4'b0001, stream: 8'b1000_0001, mutate: 1'b0};
      vecs[3] = '{w1: 4'b0110, w0: 4'b1001, stream: 8'b0110_1001, mutate: 1'b1};

      // Reset held with start asserted, then released with start low.
      resetn = 1'b0;
      bus_a.start = 1'b1; bus_a.abort = 1'b0;
      bus_b.start = 1'b1; bus_b.abort = 1'b0;
      for (int p = 0; p < int'(A_IO); p++) rf_a[p] = '0;
      for (int p = 0; p < int'(B_IO); p++) rf_b[p] = '0;
      repeat (5) @(negedge clk);
      chk("rst_held_b", 64'({bus_b.busy, bus_b.done, bus_b.serial_clock, bus_b.serial_data,
                             bus_b.serial_load, bus_b.cfg_idx}), 64'(0));
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      resetn = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         chk("rst_idle_a", 64'({bus_a.busy, bus_a.done, bus_a.serial_clock, bus_a.serial_data,
                                bus_a.serial_load, bus_a.cfg_idx}), 64'(0));
         chk("rst_idle_b", 64'({bus_b.busy, bus_b.done, bus_b.serial_clock, bus_b.serial_data,
                                bus_b.serial_load, bus_b.cfg_idx}), 64'(0));
      end

      // Table-driven small-chain loads; some vectors rewrite pad1's word after its fetch.
      for (int v = 0; v < 4; v++) begin
         rf_a[1] = vecs[v].w1;
         rf_a[0] = vecs[v].w0;
         for (int i = 7; i >= 0; i--) begin
            exp_bit_a.push_back(vecs[v].stream[i]);
            exp_idx_a.push_back((i >= 4) ? 1 : 0);
         end
         l0 = loads_a; h0 = load_hi_a; d0 = dones_a;
         pulse(1'b0);
         measure_a(40, vecs[v].mutate ? 3 : 0, busy_n, done_at);
         chk($sformatf("a%0d_busy_cycles", v), 64'(busy_n), 64'(20));
         chk($sformatf("a%0d_done_cycle", v), 64'(done_at), 64'(20));
         chk($sformatf("a%0d_loads", v), 64'(loads_a - l0), 64'(1));
         chk($sformatf("a%0d_load_len", v), 64'(load_hi_a - h0), 64'(A_DIV));
         chk($sformatf("a%0d_dones", v), 64'(dones_a - d0), 64'(1));
         chk($sformatf("a%0d_bits_left", v), 64'(exp_bit_a.size()), 64'(0));
      end

      // Start pulses while busy are ignored.
      rf_a[1] = 4'b1100; rf_a[0] = 4'b0101;
      push_a(4'b1100, 4'b0101);
      l0 = loads_a; d0 = dones_a;
      pulse(1'b0);
      busy_n = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (bus_a.busy) busy_n++;
         bus_a.start = (n == 5 || n == 12) ? 1'b1 : 1'b0;
      end
      bus_a.start = 1'b0;
      chk("a_overlap_busy_cycles", 64'(busy_n), 64'(20));
      chk("a_overlap_loads", 64'(loads_a - l0), 64'(1));
      chk("a_overlap_dones", 64'(dones_a - d0), 64'(1));
      chk("a_overlap_bits_left", 64'(exp_bit_a.size()), 64'(0));

      // start together with abort in IDLE is refused.
      @(negedge clk);
      bus_a.start = 1'b1; bus_a.abort = 1'b1;
      busy_n = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         bus_a.start = 1'b0; bus_a.abort = 1'b0;
         if (bus_a.busy) busy_n++;
      end
      chk("a_start_abort_idle_busy", 64'(busy_n), 64'(0));

      // Back-to-back: start in the cycle right after done.
      rf_a[1] = 4'b0111; rf_a[0] = 4'b1110;
      push_a(4'b0111, 4'b1110);
      push_a(4'b0111, 4'b1110);
      l0 = loads_a; d0 = dones_a;
      pulse(1'b0);
      measure_a(40, 0, busy_n, done_at);
      chk("a_b2b_first_busy", 64'(busy_n), 64'(20));
      chk("a_b2b_first_done", 64'(done_at), 64'(20));
      bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      measure_a(40, 0, busy_n, done_at);
      chk("a_b2b_second_busy", 64'(busy_n), 64'(20));
      chk("a_b2b_second_done", 64'(done_at), 64'(20));
      chk("a_b2b_loads", 64'(loads_a - l0), 64'(2));
      chk("a_b2b_dones", 64'(dones_a - d0), 64'(2));
      chk("a_b2b_bits_left", 64'(exp_bit_a.size()), 64'(0));

      // Default chain, random words.
      for (int p = 0; p < int'(B_IO); p++) rf_b[p] = B_CB'($urandom);
      run_b_full("b_full1");

      // Abort on the 7th serial clock edge.
      for (int p = 0; p < int'(B_IO); p++) saved_b[p] = applied_b[p];
      for (int p = 0; p < int'(B_IO); p++) rf_b[p] = B_CB'($urandom);
      push_b();
      l0 = loads_b; d0 = dones_b;
      pulse(1'b1);
      begin
         int  edges;
         logic prev;
         bit  got;
         edges = 0; prev = 1'b0; got = 1'b0;
         for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (bus_b.serial_clock && !prev) edges++;
            prev = bus_b.serial_clock;
            if (edges == 7) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) fail("b_abort_edge_timeout");
      end
      bus_b.abort = 1'b1;
      @(posedge clk); #1;
      bus_b.abort = 1'b0;
      @(negedge clk);
      chk("b_abort_busy", 64'(bus_b.busy), 64'(0));
      chk("b_abort_sclk", 64'(bus_b.serial_clock), 64'(0));
      chk("b_abort_sload", 64'(bus_b.serial_load), 64'(0));
      chk("b_abort_done", 64'(bus_b.done), 64'(0));
      exp_bit_b.delete();
      repeat (60) @(negedge clk);
      chk("b_abort_loads", 64'(loads_b - l0), 64'(0));
      chk("b_abort_dones", 64'(dones_b - d0), 64'(0));
      mism = 0;
      for (int p = 0; p < int'(B_IO); p++) if (applied_b[p] !== saved_b[p]) mism++;
      chk("b_abort_applied_changed_pads", 64'(mism), 64'(0));

      // A fresh start after abort completes normally.
      run_b_full("b_after_abort");

      // Asynchronous reset at cycle 500 of a load.
      for (int p = 0; p < int'(B_IO); p++) saved_b[p] = applied_b[p];
      for (int p = 0; p < int'(B_IO); p++) rf_b[p] = B_CB'($urandom);
      push_b();
      l0 = loads_b;
      pulse(1'b1);
      repeat (500) @(negedge clk);
      chk("b_rst_pre_busy", 64'(bus_b.busy), 64'(1));
      #2;
      resetn = 1'b0;
      #1;
      chk("b_rst_async_outputs", 64'({bus_b.busy, bus_b.done, bus_b.serial_clock,
                                      bus_b.serial_data, bus_b.serial_load, bus_b.cfg_idx}), 64'(0));
      exp_bit_b.delete();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (50) @(negedge clk);
      chk("b_rst_loads", 64'(loads_b - l0), 64'(0));
      chk("b_rst_busy_after", 64'(bus_b.busy), 64'(0));
      mism = 0;
      for (int p = 0; p < int'(B_IO); p++) if (applied_b[p] !== saved_b[p]) mism++;
      chk("b_rst_applied_changed_pads", 64'(mism), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case the sequence above stalls.
   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, want finish before 1000000 time units");
      $fatal(1);
   end
endmodule

// File: doc/gpio_cfg_sequencer.md
# gpio_cfg_sequencer

Serial configuration sequencer for the user-area GPIO pad chain. On a start request it reads one configuration word per pad from the housekeeping register file and shifts it, MSB first, into the daisy-chained per-pad GPIO control blocks (last pad first). It then pulses the chain load strobe so every pad applies its new output, output-enable, pull and mode settings at the same time. It sits between the housekeeping register bank and the pad control chain and is the only writer of that chain.

## Interface
- NUM_IO, 38, number of pads in the chain (≥1)
- CFG_BITS, 13, configuration bits per pad (≥2)
- DIV, 2, core-clock cycles per serial-clock phase (≥1)
- clk  in  1  core clock; all logic on rising edge
- resetn  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle request to begin a full chain load; sampled only in IDLE
- abort  in  1  terminate an in-progress load without asserting serial_load
- cfg_idx  out  $clog2(NUM_IO) (min 1)  pad index being read from the register file
- cfg_word  in  CFG_BITS  config word for cfg_idx; combinational (zero-latency) read
- busy  out  1  high from the cycle after start is accepted until the return to IDLE
- done  out  1  one-cycle pulse after a successful load strobe
- serial_clock  out  1  chain shift clock; data captured on its rising edge
- serial_data  out  1  chain shift data
- serial_load  out  1  chain load strobe; high for DIV cycles

## Operation
- All outputs are registered. Reset values: busy=0, done=0, serial_clock=0, serial_data=0, serial_load=0, cfg_idx=0, state=IDLE.
- States: IDLE, FETCH, CLK_LO, CLK_HI, LOAD, DONE.
- IDLE: on start=1 and abort=0, set idx=NUM_IO-1 and go to FETCH. If start and abort are both 1, stay in IDLE.
- FETCH (1 cycle): shreg<=cfg_word at cfg_idx=idx, bitcnt<=CFG_BITS-1, serial_clock=0.
- CLK_LO (DIV cycles): serial_clock=0, serial_data=shreg[MSB].
- CLK_HI (DIV cycles): serial_clock=1, serial_data unchanged. On the last cycle:
  - if bitcnt≠0: shift shreg left by 1, decrement bitcnt, go to CLK_LO.
  - else if idx≠0: decrement idx, go to FETCH.
  - else: go to LOAD.
- LOAD (DIV cycles): serial_load=1, serial_clock=0.
- DONE (1 cycle): done=1, serial_load=0. Then go to IDLE.
- serial_data follows shreg[MSB]. It changes only while serial_clock=0, so the chain sees at least DIV cycles of setup and hold around every rising edge.
- Bit order: pad NUM_IO-1 is sent first, and each word is sent MSB first. After NUM_IO×CFG_BITS edges, pad 0's word sits nearest the chain input.
- abort=1 in any state other than IDLE:
  - next cycle the state is IDLE; busy, serial_clock and serial_load are 0; done stays 0.
  - pads keep their previous applied config because load is never strobed.
  - the partially shifted chain contents are don't-care.
- start while busy=1 is ignored; it is not queued.
- cfg_word must be stable only in the FETCH cycle. Register-file writes at any other time do not affect the load in progress.
- Phase and bit counters are wide enough for DIV and CFG_BITS with no wrap. A DIV-cycle phase counter reloads on every phase entry.

## Timing
- Start accepted in cycle 0: busy=1 and state=FETCH in cycle 1.
- Each bit takes 2×DIV cycles. Each pad takes 1+2×DIV×CFG_BITS cycles.
- Total busy duration: NUM_IO×(1+2×DIV×CFG_BITS)+DIV+1 cycles. Defaults: 38×53+3 = 2017.
- First serial_clock rising edge: cycle 2+DIV after start.
- done is high in the last busy cycle. busy=0 in the following cycle, and a new start is accepted there.
- Asynchronous reset mid-operation forces all outputs to their reset values immediately. No load strobe occurs.

## Test plan
- Reset and idle: hold resetn=0 with start=1, then release with start=0.
  - All outputs stay 0 and busy stays 0 for 100 cycles.
- Basic load (NUM_IO=2, CFG_BITS=4, DIV=1): pad1 word 4'b1010, pad0 word 4'b0011, pulse start.
  - cfg_idx reads 1 then 0.
  - Sampled at the serial_clock rising edges, serial_data is 1,0,1,0,0,0,1,1.
  - serial_load=1 for 1 cycle, then done in cycle 20 after start; busy high for exactly 20 cycles.
- Defaults: random 38×13-bit words.
  - A bench shift-register model captures all 494 bits in order.
  - The applied values match the register-file contents after serial_load.
  - busy lasts 2017 cycles.
- Abort: assert abort on the 7th serial_clock edge.
  - Next cycle state is IDLE and serial_load never rises.
  - done=0 and the model's applied config is unchanged.
  - A subsequent start completes normally.
- Overlap:
  - start pulses while busy produce exactly one load and one done.
  - start with abort in IDLE leaves busy=0.
  - start in the cycle after done begins a new load.
- Async reset at cycle 500 of a defaults load: outputs drop to 0 without waiting for a clk edge, and serial_load never asserts.
